// File: rtl/jtag_debug_scan_chain_tck_if.sv
// Hub-side and debug-side signal bundle for the TCK-domain scan-chain engine.
// The master view belongs to the virtual-JTAG hub / system debug logic,
// the slave view to the scan-chain engine itself.
interface jtag_debug_scan_chain_tck_if #(
   parameter int IR_WIDTH = 2,
   parameter int NUM_IR   = 4,
   parameter int SR_WIDTH = 38
);
   logic [IR_WIDTH-1:0]        ir_in;
   logic                       vs_cdr;
   logic                       vs_sdr;
   logic                       vs_udr;
   logic                       vs_uir;
   logic                       tdi;
   logic                       tdo;
   logic [NUM_IR*SR_WIDTH-1:0] capture_data;
   logic [IR_WIDTH-1:0]        status_in;
   logic [IR_WIDTH-1:0]        ir_out;
   logic                       jtag_state_rti;
   logic                       st_ready_test_idle;
   logic [SR_WIDTH-1:0]        sr;
   logic                       update_valid;
   logic                       update_err;
   logic [IR_WIDTH-1:0]        update_ir;
   logic [SR_WIDTH-1:0]        update_data;

   modport master (
      output ir_in, vs_cdr, vs_sdr, vs_udr, vs_uir, tdi,
      output capture_data, status_in, jtag_state_rti,
      input  tdo, ir_out, st_ready_test_idle, sr,
      input  update_valid, update_err, update_ir, update_data
   );

   modport slave (
      input  ir_in, vs_cdr, vs_sdr, vs_udr, vs_uir, tdi,
      input  capture_data, status_in, jtag_state_rti,
      output tdo, ir_out, st_ready_test_idle, sr,
      output update_valid, update_err, update_ir, update_data
   );
endinterface

// File: rtl/jtag_debug_scan_chain_tck.sv
// TCK-domain scan-chain engine for the CPU JTAG debug module.
// Supports NUM_IR instructions with individual DR lengths, a one-bit BYPASS
// path for unimplemented IR codes, an Update-DR port that reports whether the
// shift count matched the DR length, and a status synchroniser to ir_out.
module jtag_debug_scan_chain_tck #(
   parameter int                  IR_WIDTH    = 2,
   parameter int                  NUM_IR      = 4,
   parameter int                  SR_WIDTH    = 38,
   parameter logic [NUM_IR*8-1:0] DR_LEN      = {8'd16, 8'd38, 8'd38, 8'd37},
   parameter int                  SYNC_STAGES = 2
) (
   input logic                         tck,
   input logic                         reset,
   jtag_debug_scan_chain_tck_if.slave  jtag
);

   logic [SR_WIDTH-1:0] sr_q;
   logic [SR_WIDTH-1:0] sr_shifted;
   logic [SR_WIDTH:0]   sr_ext;
   logic [SR_WIDTH-1:0] capture_word;
   logic [SR_WIDTH-1:0] update_data_q;
   logic [7:0]          dr_len_q;
   logic [7:0]          shift_cnt_q;
   logic [7:0]          shift_cnt_inc;
   logic [7:0]          ir_len;
   logic                ir_known;
   logic                bypass_q;
   logic [IR_WIDTH-1:0] cur_ir_q;
   logic                update_valid_q;
   logic                update_err_q;
   logic [IR_WIDTH-1:0] sync_q [SYNC_STAGES];

   // Decode ir_in into its DR length, capture slice and implemented flag.
   always_comb begin
      ir_known     = 1'b0;
      ir_len       = 8'd1;
      capture_word = '0;
      for (int unsigned i = 0; i < NUM_IR; i++) begin
         if (jtag.ir_in == IR_WIDTH'(i)) begin
            ir_known     = 1'b1;
            ir_len       = DR_LEN[8*i +: 8];
            capture_word = jtag.capture_data[SR_WIDTH*i +: SR_WIDTH];
         end
      end
   end

   // Shift the low dr_len bits one place toward bit 0; tdi enters at bit dr_len-1.
   always_comb begin
      sr_ext     = {1'b0, sr_q};
      sr_shifted = sr_q;
      for (int unsigned k = 0; k < SR_WIDTH; k++) begin
         if ((k + 1) == 32'(dr_len_q)) begin
            sr_shifted[k] = jtag.tdi;
         end else if ((k + 1) < 32'(dr_len_q)) begin
            sr_shifted[k] = sr_ext[k+1];
         end
      end
   end

   assign shift_cnt_inc = (shift_cnt_q == 8'hFF) ? 8'hFF : shift_cnt_q + 8'd1;

   // Shift register and shift counter; Shift-DR takes priority over Capture-DR.
   always_ff @(posedge tck) begin
      if (reset) begin
         sr_q        <= '0;
         shift_cnt_q <= '0;
      end else if (jtag.vs_sdr) begin
         // A coinciding capture still restarts the count, so this shift is bit 1.
         sr_q        <= sr_shifted;
         shift_cnt_q <= jtag.vs_cdr ? 8'd1 : shift_cnt_inc;
      end else if (jtag.vs_cdr) begin
         sr_q        <= bypass_q ? '0 : capture_word;
         shift_cnt_q <= '0;
      end
   end

   // Instruction register: latch IR code, its DR length and bypass on Update-IR.
   always_ff @(posedge tck) begin
      if (reset) begin
         cur_ir_q <= '0;
         dr_len_q <= DR_LEN[7:0];
         bypass_q <= 1'b0;
      end else if (jtag.vs_uir) begin
         cur_ir_q <= jtag.ir_in;
         dr_len_q <= ir_len;
         bypass_q <= ~ir_known;
      end
   end

   // Update-DR write-back: capture sr before this cycle's shift and flag the length check.
   always_ff @(posedge tck) begin
      if (reset) begin
         update_data_q  <= '0;
         update_valid_q <= 1'b0;
         update_err_q   <= 1'b0;
      end else begin
         update_valid_q <= 1'b0;
         update_err_q   <= 1'b0;
         if (jtag.vs_udr) begin
            update_data_q <= sr_q;
            if (!bypass_q) begin
               update_valid_q <= (shift_cnt_q == dr_len_q);
               update_err_q   <= (shift_cnt_q != dr_len_q);
            end
         end
      end
   end

   // Status synchroniser chain from the system-clock domain.
   always_ff @(posedge tck) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= jtag.status_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign jtag.tdo                = sr_q[0];
   assign jtag.sr                 = sr_q;
   assign jtag.ir_out             = sync_q[SYNC_STAGES-1];
   assign jtag.st_ready_test_idle = jtag.jtag_state_rti;
   assign jtag.update_valid       = update_valid_q;
   assign jtag.update_err         = update_err_q;
   assign jtag.update_ir          = cur_ir_q;
   assign jtag.update_data        = update_data_q;

endmodule
